// File: rtl/is_uart_pkg.sv
// is_uart_pkg: shared UART types, default line settings and bit-period helper
package is_uart_pkg;
  localparam int DEF_CLK_FREQ = 50_000_000;
  localparam int DEF_BAUD = 115_200;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return baud > 0 ? (clk_freq + baud / 2) / baud : 0;
  endfunction
endpackage

// File: rtl/is_uart_baud_tick.sv
// is_uart_baud_tick: one-cycle tick every CLKS_PER_BIT enabled cycles, restartable by clear
module is_uart_baud_tick import is_uart_pkg::*; #(
  parameter int CLKS_PER_BIT = clks_per_bit(DEF_CLK_FREQ, DEF_BAUD)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  logic [CW-1:0] cnt;
  assign tick = enable && cnt == CW'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable) cnt <= tick ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/is_uart_tx.sv
// is_uart_tx: valid/ready fed UART transmitter, start + data LSB first + optional parity + stop
module is_uart_tx import is_uart_pkg::*; #(
  parameter int CLK_FREQ   = DEF_CLK_FREQ,
  parameter int BAUD       = DEF_BAUD,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DATA_BITS-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic                 tx_busy_o,
  output logic                 uart_txd_o
);
  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  if (CPB < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY_EN < 0 || PARITY_EN > 1 ||
      PARITY_ODD < 0 || PARITY_ODD > 1 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
    $error("is_uart_tx: illegal parameter set");
  end
  uart_tx_state_t state, state_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic par, par_n, txd_n, ready_n, busy_n, tick, hs;
  assign hs = tx_valid_i & tx_ready_o;
  is_uart_baud_tick #(.CLKS_PER_BIT(CPB)) u_tick (
    .clk_i(clk_i), .rst_i(rst_i), .clear(hs), .enable(state != IDLE), .tick(tick)
  );
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      par        <= 1'b0;
      uart_txd_o <= 1'b1;
      tx_ready_o <= 1'b0;
      tx_busy_o  <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      bit_cnt    <= bit_cnt_n;
      par        <= par_n;
      uart_txd_o <= txd_n;
      tx_ready_o <= ready_n;
      tx_busy_o  <= busy_n;
    end
  end
  // The line is registered, so each transition loads the level of the bit being entered.
  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    par_n     = par;
    txd_n     = uart_txd_o;
    ready_n   = tx_ready_o;
    busy_n    = tx_busy_o;
    case (state)
      IDLE: begin
        txd_n   = 1'b1;
        ready_n = !hs;
        if (hs) begin
          state_n   = START;
          shreg_n   = tx_data_i;
          par_n     = ^tx_data_i ^ 1'(PARITY_ODD);
          bit_cnt_n = '0;
          txd_n     = 1'b0;
          busy_n    = 1'b1;
        end
      end
      START: if (tick) begin
        state_n = DATA;
        txd_n   = shreg[0];
      end
      DATA: if (tick) begin
        shreg_n   = shreg >> 1;
        bit_cnt_n = bit_cnt + 1'b1;
        txd_n     = shreg[1];
        if (bit_cnt == 4'(DATA_BITS - 1)) begin
          bit_cnt_n = '0;
          state_n   = PARITY_EN != 0 ? PARITY : STOP;
          txd_n     = PARITY_EN != 0 ? par : 1'b1;
        end
      end
      PARITY: if (tick) begin
        state_n = STOP;
        txd_n   = 1'b1;
      end
      STOP: if (tick) begin
        bit_cnt_n = bit_cnt + 1'b1;
        if (bit_cnt == 4'(STOP_BITS - 1)) begin
          state_n   = IDLE;
          bit_cnt_n = '0;
          ready_n   = 1'b1;
          busy_n    = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
